alu_issue_ctrl: RTL

Initiator and consumer for the datapath ALU's combinational port: alu_a, alu_b and alu_sel drive the ALU inputs, and alu_r and alu_z are its outputs. It accepts an operation with a valid/ready handshake and decodes the MIPS-style ALUOp/funct pair into the 3-bit ALU select code. It drives registered operands and select into the ALU, captures R/ZFlag one cycle later, and presents the result downstream with a valid/ready handshake. It sits between the multicycle control FSM and the ALU.

---
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for the combinational datapath ALU: decodes ALUOp/funct,
// registers operands and select into the ALU, captures R/Z and hands off downstream.
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic             r_pend_illegal;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_op_count;

  logic [2:0]       w_sel;
  logic             w_illegal;

  // Undecodable ops select 011, which the ALU resolves to R=0, Z=1.
  always_comb begin
    w_sel     = 3'b011;
    w_illegal = 1'b0;
    case (alu_op)
      2'b00: w_sel = 3'b010;
      2'b01: w_sel = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: w_sel = 3'b010;
          6'b100010: w_sel = 3'b110;
          6'b100100: w_sel = 3'b000;
          6'b100101: w_sel = 3'b001;
          6'b101010: w_sel = 3'b111;
          default:   w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_sel      <= 3'b000;
      r_pend_illegal <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_op_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_alu_a        <= op_a;
            r_alu_b        <= op_b;
            r_alu_sel      <= w_sel;
            r_pend_illegal <= w_illegal;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_out_result  <= alu_r;
          r_out_zero    <= alu_z;
          r_out_illegal <= r_pend_illegal;
          r_out_valid   <= 1'b1;
          r_state       <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_sel     = r_alu_sel;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_illegal = r_out_illegal;
  assign op_count    = r_op_count;

endmodule
